debug_sequencer: RTL and testbench
==================================

DEBUG_SEQUENCER -- requirements
Module: debug_sequencer

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 48, number of 32-bit debug words dumped per dump (1..64).
REQ-002 SHALL have parameter CMD_CONT, default 8'h63, command byte that starts continuous run.
REQ-003 SHALL have parameter CMD_STEP, default 8'h73, command byte that advances the pipeline one clock.
REQ-004 SHALL have parameter CMD_DUMP, default 8'h64, command byte that dumps without advancing.
REQ-005 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: rx_data  in  8  received UART byte; rx_done_tick  in  1  one-cycle pulse, rx_data valid.
REQ-008 SHALL have ports: tx_data  out  8  byte to transmit; tx_start  out  1  one-cycle pulse requesting transmission; tx_done_tick  in  1  one-cycle pulse, byte sent.
REQ-009 SHALL have ports: halt  in  1  pipeline has reached end of program; ena_pip  out  1  pipeline clock enable.
REQ-010 SHALL have ports: word_sel  out  6  index of debug word to present; word_data  in  32  selected word, combinational from word_sel.
REQ-011 SHALL have port led  out  8  status.

Function
REQ-012 SHALL implement states IDLE, RUN, STEP, DUMP_LOAD, DUMP_SEND, DUMP_WAIT.
REQ-013 IDLE: on rx_done_tick, SHALL go to RUN if rx_data==CMD_CONT and halted==0, to STEP if rx_data==CMD_STEP, to DUMP_LOAD if rx_data==CMD_DUMP; any other byte, or CMD_CONT with halted==1, ignored (stay IDLE).
REQ-014 rx_done_tick in any state other than IDLE SHALL be ignored; no command queuing.
REQ-015 ena_pip SHALL be 1 exactly when (state==RUN and halt==0) or state==STEP (combinational from state and halt).
REQ-016 RUN: when halt==1 at a clock edge, SHALL set halted=1 and go to DUMP_LOAD; otherwise stay RUN.
REQ-017 STEP: SHALL last exactly one cycle (one ena_pip pulse), then go to DUMP_LOAD regardless of halt.
REQ-018 Entry into DUMP_LOAD from IDLE/RUN/STEP SHALL clear word index and byte index to 0.
REQ-019 word_sel SHALL equal registered word index, zero-extended to 6 bits.
REQ-020 DUMP_LOAD: SHALL latch word_data into a 32-bit shift register, then go to DUMP_SEND.
REQ-021 DUMP_SEND: SHALL drive tx_start=1 for this single cycle with tx_data = shift[31:24], then go to DUMP_WAIT; bytes sent MSB first.
REQ-022 DUMP_WAIT: on tx_done_tick: if byte index<3, increment it, shift register left 8, go DUMP_SEND; else if word index<NUM_WORDS-1, increment word index, clear byte index, go DUMP_LOAD; else go IDLE.
REQ-023 Each dump SHALL emit exactly 4*NUM_WORDS bytes with exactly one tx_start per byte; tx_start SHALL never be asserted outside DUMP_SEND.
REQ-024 tx_data SHALL hold its value from DUMP_SEND until the next DUMP_SEND.
REQ-025 led[0]=(state==RUN), led[1]=(state in DUMP_*), led[2]=halted, led[7:3]=0.
REQ-026 halted SHALL be sticky; cleared only by reset.

Reset
REQ-027 reset==0 SHALL immediately force state=IDLE, word index=0, byte index=0, shift register=0, halted=0, tx_data=0, tx_start=0, ena_pip=0, word_sel=0, led=0, including mid-run or mid-dump; no partial dump resumes after release.
REQ-028 After reset release, first command SHALL be accepted on first rx_done_tick.

Verification
REQ-029 Reset, rx 8'h64, word_data=32'hA0B1C2D3+word_sel, NUM_WORDS=2 -> tx bytes A0,B1,C2,D3,A0,B1,C2,D4; ena_pip never 1; IDLE afterward.
REQ-030 rx 8'h73 -> ena_pip high exactly one cycle, then full 4*NUM_WORDS-byte dump; repeat twice -> two pulses total.
REQ-031 rx 8'h63, halt raised after 10 cycles -> ena_pip high exactly 10 cycles, led[2]=1, dump follows; later 8'h63 -> ignored, 8'h73 -> accepted.
REQ-032 rx 8'h41 in IDLE and 8'h73 during dump -> no state change, no extra ena_pip or tx_start.
REQ-033 tx_done_tick delayed 100 cycles per byte -> tx_start pulses spaced accordingly, never two without intervening tx_done_tick.
REQ-034 reset asserted mid-dump (after 5 bytes) -> all outputs 0 immediately; after release no further tx_start until new command.

Source files
------------

// File: rtl/debug_sequencer.sv
`default_nettype none
//============================================================================
// Module      : debug_sequencer
// Description : UART-driven debug controller for a pipelined core. Single
//               byte commands start a continuous run, advance the pipeline
//               by one clock, or dump the debug words without advancing.
//               Every run/step ends in a dump of NUM_WORDS 32-bit words,
//               sent as bytes MSB first, one tx_start per byte.
// Revision    : 1.0 - initial release
//============================================================================
module debug_sequencer #(
    parameter int          NUM_WORDS = 48,
    parameter logic [7:0]  CMD_CONT  = 8'h63,
    parameter logic [7:0]  CMD_STEP  = 8'h73,
    parameter logic [7:0]  CMD_DUMP  = 8'h64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_done_tick,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done_tick,
    input  logic        halt,
    output logic        ena_pip,
    output logic [5:0]  word_sel,
    input  logic [31:0] word_data,
    output logic [7:0]  led
);

    // State encoding
    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_run       = 3'd1;
    localparam logic [2:0] c_st_step      = 3'd2;
    localparam logic [2:0] c_st_dump_load = 3'd3;
    localparam logic [2:0] c_st_dump_send = 3'd4;
    localparam logic [2:0] c_st_dump_wait = 3'd5;

    // Index of the final word of a dump
    localparam logic [5:0] c_last_word = 6'(NUM_WORDS - 1);
    // Index of the final byte within a word
    localparam logic [1:0] c_last_byte = 2'd3;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [5:0]  r_word_idx;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_shift;
    logic        r_halted;
    logic [7:0]  r_tx_data;

    logic        w_in_dump;
    logic        w_start_dump;

    // A dump begins whenever a non-dump state hands over to DUMP_LOAD
    assign w_in_dump    = (r_state == c_st_dump_load) ||
                          (r_state == c_st_dump_send) ||
                          (r_state == c_st_dump_wait);
    assign w_start_dump = !w_in_dump && (w_state_nxt == c_st_dump_load);

    // Next-state decode; commands are only honoured while idle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (rx_done_tick) begin
                    if (rx_data == CMD_CONT && !r_halted) begin
                        w_state_nxt = c_st_run;
                    end else if (rx_data == CMD_STEP) begin
                        w_state_nxt = c_st_step;
                    end else if (rx_data == CMD_DUMP) begin
                        w_state_nxt = c_st_dump_load;
                    end
                end
            end
            c_st_run: begin
                if (halt) begin
                    w_state_nxt = c_st_dump_load;
                end
            end
            c_st_step: begin
                w_state_nxt = c_st_dump_load;
            end
            c_st_dump_load: begin
                w_state_nxt = c_st_dump_send;
            end
            c_st_dump_send: begin
                w_state_nxt = c_st_dump_wait;
            end
            c_st_dump_wait: begin
                if (tx_done_tick) begin
                    if (r_byte_idx != c_last_byte) begin
                        w_state_nxt = c_st_dump_send;
                    end else if (r_word_idx != c_last_word) begin
                        w_state_nxt = c_st_dump_load;
                    end else begin
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // State, dump indices, shift register, sticky halt flag and tx byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_word_idx <= 6'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= 32'd0;
            r_halted   <= 1'b0;
            r_tx_data  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == c_st_run && halt) begin
                r_halted <= 1'b1;
            end

            if (w_start_dump) begin
                r_word_idx <= 6'd0;
                r_byte_idx <= 2'd0;
            end

            // tx_data is loaded on the edge entering DUMP_SEND so it stays
            // stable from one DUMP_SEND to the next
            if (r_state == c_st_dump_load) begin
                r_shift   <= word_data;
                r_tx_data <= word_data[31:24];
            end

            if (r_state == c_st_dump_wait && tx_done_tick) begin
                if (r_byte_idx != c_last_byte) begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                    r_shift    <= {r_shift[23:0], 8'd0};
                    r_tx_data  <= r_shift[23:16];
                end else if (r_word_idx != c_last_word) begin
                    r_word_idx <= r_word_idx + 6'd1;
                    r_byte_idx <= 2'd0;
                end
            end
        end
    end

    // Outputs decoded from state; all fall to zero while reset is low
    always_comb begin
        ena_pip  = ((r_state == c_st_run) && !halt) || (r_state == c_st_step);
        tx_start = (r_state == c_st_dump_send);
        tx_data  = r_tx_data;
        word_sel = r_word_idx;
        led      = {5'd0, r_halted, w_in_dump, (r_state == c_st_run)};
    end

endmodule
`default_nettype wire

// File: tb/tb_debug_sequencer.sv
`default_nettype none
//============================================================================
// Module      : tb_debug_sequencer
// Description : Directed self-checking bench for debug_sequencer with
//               NUM_WORDS=2 and a simple UART transmitter responder.
// Revision    : 1.0 - initial release
//============================================================================
module tb_debug_sequencer;

    localparam int NW = 2;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic [7:0]  rx_data      = 8'd0;
    logic        rx_done_tick = 1'b0;
    logic        tx_done_tick = 1'b0;
    logic        halt         = 1'b0;
    logic [31:0] word_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        ena_pip;
    logic [5:0]  word_sel;
    logic [7:0]  led;

    assign word_data = 32'hA0B1C2D3 + {26'd0, word_sel};

    always #5 clk = ~clk;

    debug_sequencer #(.NUM_WORDS(NW)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_done_tick (tx_done_tick),
        .halt         (halt),
        .ena_pip      (ena_pip),
        .word_sel     (word_sel),
        .word_data    (word_data),
        .led          (led)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hand-computed byte stream for one dump of two words
    logic [7:0] exp_bytes [8] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0, 8'hB1, 8'hC2, 8'hD4};

    // Monitor: records bytes, start times, pipeline-enable cycles, overlaps
    logic [7:0] bytes_q[$];
    int         start_cyc_q[$];
    int         cyc         = 0;
    int         ena_cnt     = 0;
    int         ovl_cnt     = 0;
    bit         outstanding = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ena_pip) ena_cnt = ena_cnt + 1;
        if (tx_done_tick) outstanding = 1'b0;
        if (tx_start) begin
            if (outstanding) ovl_cnt = ovl_cnt + 1;
            outstanding = 1'b1;
            bytes_q.push_back(tx_data);
            start_cyc_q.push_back(cyc);
        end
    end

    // UART transmitter model: acknowledges each byte after done_delay cycles
    int done_delay = 2;
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                repeat (done_delay) @(posedge clk);
                #1 tx_done_tick = 1'b1;
                @(posedge clk);
                #1 tx_done_tick = 1'b0;
            end
        end
    end

    task automatic send_cmd(input logic [7:0] b);
        @(posedge clk);
        #1 rx_data = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1 rx_done_tick = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        repeat (2) @(negedge clk);
        while (led[1:0] != 2'b00 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(n >= budget), 32'd0);
    endtask

    task automatic check_dump(input string tag, input int base);
        check({tag, "_nbytes"}, 32'(bytes_q.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < bytes_q.size())
                check($sformatf("%s_byte%0d", tag, i), {24'd0, bytes_q[base + i]}, {24'd0, exp_bytes[i]});
        end
    endtask

    initial begin
        int base;
        int ena0;
        int n;

        // Reset state, asserted from time zero
        #2;
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_ena_pip",  {31'd0, ena_pip},  32'd0);
        check("rst_tx_data",  {24'd0, tx_data},  32'd0);
        check("rst_word_sel", {26'd0, word_sel}, 32'd0);
        check("rst_led",      {24'd0, led},      32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Plain dump: no pipeline advance, returns idle
        base = bytes_q.size(); ena0 = ena_cnt;
        send_cmd(8'h64);
        wait_idle(500);
        check_dump("dump", base);
        check("dump_ena", 32'(ena_cnt - ena0), 32'd0);
        check("dump_led", {24'd0, led}, 32'd0);

        // Single steps, twice
        for (int k = 0; k < 2; k++) begin
            base = bytes_q.size();
            send_cmd(8'h73);
            wait_idle(500);
            check_dump($sformatf("step%0d", k), base);
        end
        check("step_ena", 32'(ena_cnt - ena0), 32'd2);

        // Unknown byte in idle is ignored
        base = bytes_q.size(); ena0 = ena_cnt;
        send_cmd(8'h41);
        repeat (5) @(negedge clk);
        check("junk_led", {24'd0, led}, 32'd0);
        check("junk_ena", 32'(ena_cnt - ena0), 32'd0);
        check("junk_tx",  32'(bytes_q.size() - base), 32'd0);

        // Step command during a dump is ignored
        base = bytes_q.size(); ena0 = ena_cnt;
        send_cmd(8'h64);
        repeat (3) @(posedge clk);
        send_cmd(8'h73);
        wait_idle(500);
        check_dump("busy", base);
        check("busy_ena", 32'(ena_cnt - ena0), 32'd0);

        // Continuous run, halt after ten cycles
        base = bytes_q.size(); ena0 = ena_cnt;
        send_cmd(8'h63);
        repeat (10) @(posedge clk);
        #1 halt = 1'b1;
        wait_idle(500);
        check("cont_ena", 32'(ena_cnt - ena0), 32'd10);
        check("cont_led", {24'd0, led}, 32'h04);
        check_dump("cont", base);

        // Continue after halt is refused
        base = bytes_q.size(); ena0 = ena_cnt;
        send_cmd(8'h63);
        repeat (5) @(negedge clk);
        check("cont2_led", {24'd0, led}, 32'h04);
        check("cont2_ena", 32'(ena_cnt - ena0), 32'd0);
        check("cont2_tx",  32'(bytes_q.size() - base), 32'd0);

        // Step after halt still works
        send_cmd(8'h73);
        wait_idle(500);
        check("hstep_ena", 32'(ena_cnt - ena0), 32'd1);
        check_dump("hstep", base);

        // Slow transmitter: 100-cycle acknowledge per byte
        done_delay = 100;
        base = bytes_q.size(); ena0 = ovl_cnt;
        send_cmd(8'h64);
        wait_idle(2000);
        check_dump("slow", base);
        check("slow_overlap", 32'(ovl_cnt - ena0), 32'd0);
        for (int i = 1; i < 8; i++) begin
            if (base + i < start_cyc_q.size())
                check($sformatf("slow_gap%0d", i),
                      32'(start_cyc_q[base + i] - start_cyc_q[base + i - 1]),
                      (i == 4) ? 32'd102 : 32'd101);
        end

        // Reset in the middle of a dump
        done_delay = 3;
        base = bytes_q.size();
        send_cmd(8'h64);
        n = 0;
        while (bytes_q.size() - base < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_timeout", 32'(n >= 500), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("mid_tx_start", {31'd0, tx_start}, 32'd0);
        check("mid_ena_pip",  {31'd0, ena_pip},  32'd0);
        check("mid_tx_data",  {24'd0, tx_data},  32'd0);
        check("mid_word_sel", {26'd0, word_sel}, 32'd0);
        check("mid_led",      {24'd0, led},      32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        base = bytes_q.size();
        repeat (50) @(negedge clk);
        check("post_rst_tx", 32'(bytes_q.size() - base), 32'd0);

        // First command after reset is accepted and dumps cleanly
        send_cmd(8'h64);
        wait_idle(500);
        check_dump("after_rst", base);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
